// File: rtl/count_enable_gen.sv
// ============================================================================
// count_enable_gen
// ----------------------------------------------------------------------------
// Purpose:
//   Generates the count-enable strobe for a downstream 3-bit up counter.
//   The strobe comes from one of two sources:
//     * step mode (Mode = 0): one strobe per debounced pushbutton press.
//     * run mode  (Mode = 1): one strobe every PRESCALE clock cycles.
//   Hold = 1 suppresses every strobe and freezes the run-mode prescaler.
//   En is registered, so the counter can use it directly in the Clk domain.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable synchronised samples (after the first
//                     change is seen) needed to accept a press or a release.
//                     Must be >= 2.
//   PRESCALE        - run-mode strobe period in Clk cycles. Must be >= 2.
//
// Ports:
//   Clk     in   1  system clock, all state changes on the rising edge
//   Rst     in   1  synchronous, active-high reset
//   Btn     in   1  raw asynchronous pushbutton, active-high
//   Mode    in   1  0 = step mode, 1 = run mode
//   Hold    in   1  1 = no strobes, prescaler frozen
//   En      out  1  registered single-cycle count-enable strobe
//   Pressed out  1  registered debounced button level
//   State   out  2  debounce FSM state (IDLE=00, PRESS_WAIT=01, HELD=10,
//                   RELEASE_WAIT=11), for debug
// ============================================================================
module count_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESCALE        = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Btn,
    input  logic       Mode,
    input  logic       Hold,
    output logic       En,
    output logic       Pressed,
    output logic [1:0] State
);

    // ------------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------------
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'b00,
        S_PRESS_WAIT   = 2'b01,
        S_HELD         = 2'b10,
        S_RELEASE_WAIT = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic            r_s1;
    logic            r_s2;
    state_t          r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_pressed;
    logic [PS_W-1:0] r_pre;
    logic            r_en;

    logic            w_step_event;
    logic            w_tick;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser: Btn is asynchronous, only r_s2 is used below.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= Btn;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Step event: true only on the edge that moves PRESS_WAIT -> HELD, so a
    // held button yields exactly one event.
    // ------------------------------------------------------------------------
    assign w_step_event = (r_state == S_PRESS_WAIT) && r_s2 &&
                          (r_db_cnt == DB_LAST);

    // ------------------------------------------------------------------------
    // Debounce FSM. Pressed is updated together with the state so that it is
    // a true register that is 1 exactly while the state is HELD or
    // RELEASE_WAIT: it rises on entry to HELD and falls on entry to IDLE.
    // A bounce in RELEASE_WAIT returns to HELD without touching Pressed.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_s2) begin
                        r_state  <= S_PRESS_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!r_s2) begin
                        r_state <= S_IDLE;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state   <= S_HELD;
                        r_pressed <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                S_HELD: begin
                    if (!r_s2) begin
                        r_state  <= S_RELEASE_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (r_s2) begin
                        r_state <= S_HELD;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_state   <= S_IDLE;
                        r_pressed <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_db_cnt  <= '0;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler: cleared whenever step mode is selected, so a switch into run
    // mode always waits a full PRESCALE period for its first strobe. Hold
    // freezes it in place.
    // ------------------------------------------------------------------------
    assign w_tick = Mode && !Hold && (r_pre == PS_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pre <= '0;
        end else if (!Mode) begin
            r_pre <= '0;
        end else if (!Hold) begin
            if (r_pre == PS_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PS_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output strobe. Events from the non-selected source, or arriving during
    // Hold, are dropped rather than queued.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_en <= 1'b0;
        end else begin
            r_en <= !Hold && (Mode ? w_tick : w_step_event);
        end
    end

    assign En      = r_en;
    assign Pressed = r_pressed;
    assign State   = r_state;

endmodule

// File: tb/tb_count_enable_gen.sv
// ============================================================================
// tb_count_enable_gen
// ----------------------------------------------------------------------------
// Self-checking bench for count_enable_gen. A behavioural model tracks the
// debounced level as "how many consecutive synchronised samples disagree
// with the accepted level" and the run-mode strobe as "every PRESCALE-th
// enabled cycle since the last clear". Directed scenarios also check fixed
// edge numbers.
// ============================================================================
module tb_count_enable_gen;

    localparam int DB = 4;
    localparam int PS = 8;

    logic       Clk;
    logic       Rst;
    logic       Btn;
    logic       Mode;
    logic       Hold;
    logic       En;
    logic       Pressed;
    logic [1:0] State;

    int n_checks = 0;
    int n_fail   = 0;

    count_enable_gen #(
        .DEBOUNCE_CYCLES (DB),
        .PRESCALE        (PS)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Btn     (Btn),
        .Mode    (Mode),
        .Hold    (Hold),
        .En      (En),
        .Pressed (Pressed),
        .State   (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------------
    // Reference model, evaluated on every rising edge with the inputs that
    // the DUT samples on that same edge.
    // ------------------------------------------------------------------------
    logic m_s1  = 1'b0;
    logic m_s2  = 1'b0;
    logic m_lvl = 1'b0;   // accepted (debounced) level
    int   m_run = 0;      // consecutive samples disagreeing with m_lvl
    int   m_n   = 0;      // enabled run-mode cycles since last clear
    logic m_en  = 1'b0;
    logic m_step;
    logic m_tick;

    always @(posedge Clk) begin
        if (Rst) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_lvl = 1'b0;
            m_run = 0;
            m_n   = 0;
            m_en  = 1'b0;
        end else begin
            m_step = 1'b0;
            if (m_s2 != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == DB + 1) begin
                    m_lvl  = m_s2;
                    m_run  = 0;
                    m_step = m_s2;
                end
            end else begin
                m_run = 0;
            end
            m_tick = 1'b0;
            if (!Mode) begin
                m_n = 0;
            end else if (!Hold) begin
                m_n    = m_n + 1;
                m_tick = ((m_n % PS) == 0);
            end
            m_en = !Hold && (Mode ? m_tick : m_step);
            m_s2 = m_s1;
            m_s1 = Btn;
        end
    end

    function automatic logic [3:0] model_obs();
        return {m_en, m_lvl, m_lvl, (m_run != 0)};
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic step_clk();
        @(posedge Clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int n_en;
        int first;
        Btn  = 1'b1;
        Mode = 1'b1;
        Hold = 1'b0;
        Rst  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step_clk();
            n_checks++;
            if ({En, Pressed, State} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_state edge %0d: got {En,Pressed,State}=%b want 0000",
                         i, {En, Pressed, State});
            end
        end
        Rst  = 1'b0;
        Mode = 1'b0;
        n_en  = 0;
        first = 0;
        for (int e = 1; e <= 16; e++) begin
            step_clk();
            n_checks++;
            if ({En, Pressed, State} !== model_obs()) begin
                n_fail++;
                $display("FAIL reset_model edge %0d: got %b want %b",
                         e, {En, Pressed, State}, model_obs());
            end
            if (En === 1'b1) begin
                n_en++;
                if (first == 0) first = e;
            end
        end
        n_checks++;
        if (n_en !== 1 || first !== 7) begin
            n_fail++;
            $display("FAIL reset_release_strobe: got %0d strobes first at edge %0d, want 1 at edge 7",
                     n_en, first);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clean_press();
        int n_en;
        int first_en;
        int first_pr;
        int first_rel;
        Mode = 1'b0;
        Hold = 1'b0;
        Btn  = 1'b0;
        repeat (12) step_clk();
        n_checks++;
        if ({Pressed, State} !== 3'b000) begin
            n_fail++;
            $display("FAIL clean_idle: got {Pressed,State}=%b want 000", {Pressed, State});
        end
        Btn = 1'b1;
        n_en = 0; first_en = 0; first_pr = 0;
        for (int e = 1; e <= 20; e++) begin
            step_clk();
            n_checks++;
            if ({En, Pressed, State} !== model_obs()) begin
                n_fail++;
                $display("FAIL press_model edge %0d: got %b want %b",
                         e, {En, Pressed, State}, model_obs());
            end
            if (En === 1'b1) begin
                n_en++;
                if (first_en == 0) first_en = e;
            end
            if (Pressed === 1'b1 && first_pr == 0) first_pr = e;
        end
        n_checks++;
        if (n_en !== 1 || first_en !== 7) begin
            n_fail++;
            $display("FAIL press_strobe: got %0d strobes first at edge %0d, want 1 at edge 7",
                     n_en, first_en);
        end
        n_checks++;
        if (first_pr !== 7) begin
            n_fail++;
            $display("FAIL press_level: Pressed rose at edge %0d, want 7", first_pr);
        end
        Btn = 1'b0;
        n_en = 0; first_rel = 0;
        for (int e = 1; e <= 20; e++) begin
            step_clk();
            if (En === 1'b1) n_en++;
            if (Pressed === 1'b0 && first_rel == 0) first_rel = e;
        end
        n_checks++;
        if (n_en !== 0 || first_rel !== 7) begin
            n_fail++;
            $display("FAIL release: got %0d strobes, Pressed fell at edge %0d, want 0 strobes and edge 7",
                     n_en, first_rel);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bounce();
        logic [5:0] pat_press;
        logic [5:0] pat_rel;
        int n_en;
        int first;
        pat_press = 6'b010101;   // bit 0 first: 1,0,1,0,1,0
        pat_rel   = 6'b101010;   // 0,1,0,1,0,1
        Mode = 1'b0;
        Hold = 1'b0;
        n_en = 0; first = 0;
        for (int e = 1; e <= 26; e++) begin
            Btn = (e <= 6) ? pat_press[e-1] : 1'b1;
            step_clk();
            n_checks++;
            if ({En, Pressed, State} !== model_obs()) begin
                n_fail++;
                $display("FAIL bounce_model edge %0d: got %b want %b",
                         e, {En, Pressed, State}, model_obs());
            end
            if (En === 1'b1) begin
                n_en++;
                if (first == 0) first = e;
            end
        end
        // Last 0->1 sample is edge 7; strobe lands 6 edges later.
        n_checks++;
        if (n_en !== 1 || first !== 13) begin
            n_fail++;
            $display("FAIL bounce_strobe: got %0d strobes first at edge %0d, want 1 at edge 13",
                     n_en, first);
        end
        n_en = 0;
        for (int e = 1; e <= 20; e++) begin
            Btn = (e <= 6) ? pat_rel[e-1] : 1'b0;
            step_clk();
            if (En === 1'b1) n_en++;
        end
        n_checks++;
        if (n_en !== 0 || Pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL release_bounce: got %0d strobes Pressed=%b, want 0 strobes Pressed=0",
                     n_en, Pressed);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_run();
        logic [2:0] cnt3;
        Btn  = 1'b0;
        Mode = 1'b1;
        Hold = 1'b0;
        Rst  = 1'b1;
        step_clk();
        Rst  = 1'b0;
        cnt3 = 3'd0;
        for (int e = 1; e <= 40; e++) begin
            step_clk();
            n_checks++;
            if (En !== ((e % PS) == 0)) begin
                n_fail++;
                $display("FAIL run_strobe edge %0d: got En=%b want %b", e, En, ((e % PS) == 0));
            end
            if (En === 1'b1) cnt3 = cnt3 + 3'd1;
        end
        n_checks++;
        if (cnt3 !== 3'd5) begin
            n_fail++;
            $display("FAIL run_counter: got %0d want 5", cnt3);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_hold();
        logic want;
        Btn  = 1'b0;
        Mode = 1'b1;
        Hold = 1'b0;
        Rst  = 1'b1;
        step_clk();
        Rst  = 1'b0;
        for (int e = 1; e <= 36; e++) begin
            Hold = (e >= 11 && e <= 22);
            step_clk();
            want = (e == 8 || e == 28 || e == 36);
            n_checks++;
            if (En !== want || {En, Pressed, State} !== model_obs()) begin
                n_fail++;
                $display("FAIL hold edge %0d: got En=%b want %b (model %b)", e, En, want, model_obs());
            end
        end
        Hold = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_mode_switch();
        logic want;
        Btn  = 1'b0;
        Mode = 1'b1;
        Hold = 1'b0;
        Rst  = 1'b1;
        step_clk();
        Rst  = 1'b0;
        for (int e = 1; e <= 36; e++) begin
            Mode = !(e >= 13 && e <= 20);
            step_clk();
            want = (e == 8 || e == 28 || e == 36);
            n_checks++;
            if (En !== want || {En, Pressed, State} !== model_obs()) begin
                n_fail++;
                $display("FAIL mode_switch edge %0d: got En=%b want %b (model %b)", e, En, want, model_obs());
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int   run_left;
        logic prev_en;
        run_left = 0;
        prev_en  = 1'b0;
        Rst  = 1'b0;
        Mode = 1'b0;
        Hold = 1'b0;
        for (int e = 1; e <= 4000; e++) begin
            if (run_left == 0) begin
                Btn      = $urandom_range(0, 1);
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            if ($urandom_range(0, 63) == 0) Mode = ~Mode;
            if ($urandom_range(0, 15) == 0) Hold = ~Hold;
            Rst = ($urandom_range(0, 499) == 0);
            step_clk();
            n_checks++;
            if ({En, Pressed, State} !== model_obs()) begin
                n_fail++;
                $display("FAIL random_model edge %0d: got %b want %b",
                         e, {En, Pressed, State}, model_obs());
            end
            n_checks++;
            if (prev_en === 1'b1 && En === 1'b1) begin
                n_fail++;
                $display("FAIL random_double_strobe edge %0d: got En=1 twice, want single-cycle", e);
            end
            prev_en = En;
        end
        Rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        Rst  = 1'b1;
        Btn  = 1'b0;
        Mode = 1'b0;
        Hold = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_run();
        test_hold();
        test_mode_switch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
